// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin shared 4x4 multiplier, two-stage pipeline; MULT_RR_STATS_EN adds done/stall counters
module array_multiplier (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_product
);
    // Sum of shifted partial products, one row per multiplier bit.
    always_comb begin
        o_product = '0;
        for (int i = 0; i < 4; i++) begin
            if (i_b[i]) o_product = o_product + ({4'b0000, i_a} << i);
        end
    end
endmodule

module mult_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ID_W-1:0]   resp_id,
    output logic [7:0]        resp_product
`ifdef MULT_RR_STATS_EN
    ,
    output logic [15:0]       done_count,
    output logic [15:0]       stall_count
`endif
);
    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [3:0]      r_s1_a;
    logic [3:0]      r_s1_b;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s2_valid;
    logic [ID_W-1:0] r_resp_id;
    logic [7:0]      r_resp_product;

    logic            w_found;
    logic [ID_W-1:0] w_winner;
    int              w_idx;
    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_accept;
    logic [NREQ-1:0] w_grant;
    logic [7:0]      w_product;

    assign w_s2_adv = !r_s2_valid | resp_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign w_accept = w_found & w_s1_adv & !rst;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_accept) w_grant[w_winner] = 1'b1;
    end

    assign req_ready = w_grant;

    array_multiplier u_mult (
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .o_product (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_a         <= '0;
            r_s1_b         <= '0;
            r_s1_id        <= '0;
            r_s2_valid     <= 1'b0;
            r_resp_id      <= '0;
            r_resp_product <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + ID_W'(1);
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_a  <= req_a[4*w_winner +: 4];
                    r_s1_b  <= req_b[4*w_winner +: 4];
                    r_s1_id <= w_winner;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_resp_product <= w_product;
                    r_resp_id      <= r_s1_id;
                end
            end
        end
    end

    assign resp_valid   = r_s2_valid;
    assign resp_id      = r_resp_id;
    assign resp_product = r_resp_product;

`ifdef MULT_RR_STATS_EN
    logic [15:0] r_done_count;
    logic [15:0] r_stall_count;

    // done wraps naturally; stall saturates so long stalls stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_s2_valid && resp_ready) r_done_count <= r_done_count + 16'd1;
            if (r_s2_valid && !resp_ready && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign done_count  = r_done_count;
    assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - scoreboard bench for mult_rr_scheduler
module tb_mult_rr_scheduler;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a = '0;
    logic [4*NREQ-1:0] req_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [ID_W-1:0]   resp_id;
    logic [7:0]        resp_product;
`ifdef MULT_RR_STATS_EN
    logic [15:0]       done_count;
    logic [15:0]       stall_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int resp_count   = 0;
    int done_model   = 0;
    logic [ID_W+7:0] exp_q[$];
    int              grant_q[$];

    mult_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product)
`ifdef MULT_RR_STATS_EN
        ,
        .done_count   (done_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Handshakes are resolved at the negedge: inputs are stable until the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_model = 0;
        end else begin
            tests_run++;
            if ($countones(req_ready) > 1) begin
                tests_failed++;
                $display("FAIL onehot_ready: req_ready=%b, required at most one bit", req_ready);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({ID_W'(i), 8'(req_a[4*i +: 4]) * 8'(req_b[4*i +: 4])});
                    grant_q.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                resp_count++;
                done_model++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_resp: id=%0d product=%0d, required no response", resp_id, resp_product);
                end else begin
                    logic [ID_W+7:0] e;
                    e = exp_q.pop_front();
                    if ({resp_id, resp_product} !== e) begin
                        tests_failed++;
                        $display("FAIL scoreboard: id=%0d product=%0d, required id=%0d product=%0d",
                                 resp_id, resp_product, e[ID_W+7:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd15);
        step(2);
        tests_run++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || resp_product !== 8'd0 || resp_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b product=%0d id=%0d, required 0000/0/0/0",
                     req_ready, resp_valid, resp_product, resp_id);
        end
        resp_count = 0;
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL first_grant: req_ready=%b, required 0001", req_ready);
        end
        step(1);
        req_valid = '0;
        step(3);
        tests_run++;
        if (resp_count !== 1) begin
            tests_failed++;
            $display("FAIL reset_drain: responses=%0d, required 1", resp_count);
        end
    endtask

    task automatic test_single;
        set_op(2, 4'd13, 4'd11);
        req_valid = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_ready: req_ready=%b, required 0100", req_ready);
        end
        step(1);
        req_valid = '0;
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: resp_valid=%b, required 0", resp_valid);
        end
        step(1);
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_product !== 8'd143) begin
            tests_failed++;
            $display("FAIL single_resp: valid=%b id=%0d product=%0d, required 1/2/143",
                     resp_valid, resp_id, resp_product);
        end
        step(2);
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        grant_q.delete();
        resp_count = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd15);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (k >= 1) begin
                tests_run++;
                if (resp_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rr_throughput: cycle %0d resp_valid=%b, required 1", k, resp_valid);
                end
            end
        end
        req_valid = '0;
        step(3);
        tests_run++;
        if (grant_q.size() !== 8) begin
            tests_failed++;
            $display("FAIL rr_grant_count: grants=%0d, required 8", grant_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (grant_q[k] !== k % 4) begin
                    tests_failed++;
                    $display("FAIL rr_order: grant %0d went to %0d, required %0d", k, grant_q[k], k % 4);
                end
            end
        end
        tests_run++;
        if (resp_count !== 8) begin
            tests_failed++;
            $display("FAIL rr_resp_count: responses=%0d, required 8", resp_count);
        end
    endtask

    task automatic test_backpressure;
        grant_q.delete();
        resp_count = 0;
        resp_ready = 1'b0;
        set_op(0, 4'd5, 4'd6);
        set_op(1, 4'd7, 4'd8);
        req_valid = 4'b0011;
        step(2);
        for (int r = 0; r < 2; r++) begin
            tests_run++;
            if (grant_q.size() !== 2 || req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_accepts: grants=%0d ready=%b, required 2/0000", grant_q.size(), req_ready);
            end
            tests_run++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_product !== 8'd30) begin
                tests_failed++;
                $display("FAIL bp_stable: valid=%b id=%0d product=%0d, required 1/0/30",
                         resp_valid, resp_id, resp_product);
            end
            step(3);
        end
        req_valid = '0;
        resp_ready = 1'b1;
        step(3);
        tests_run++;
        if (resp_count !== 2 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bp_drain: responses=%0d pending=%0d, required 2/0", resp_count, exp_q.size());
        end
    endtask

    task automatic test_corner;
        grant_q.delete();
        set_op(3, 4'd15, 4'd15);
        req_valid = 4'b1000;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL corner_last: req_ready=%b, required 1000", req_ready);
        end
        step(1);
        set_op(0, 4'd0, 4'd9);
        req_valid = 4'b1001;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL corner_wrap: req_ready=%b, required 0001", req_ready);
        end
        step(1);
        set_op(1, 4'd1, 4'd7);
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        step(3);
        tests_run++;
        if (grant_q.size() !== 3 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL corner_drain: grants=%0d pending=%0d, required 3/0", grant_q.size(), exp_q.size());
        end
    endtask

    task automatic test_mid_reset;
        int base;
        resp_ready = 1'b0;
        req_valid = 4'b0011;
        step(3);
        req_valid = '0;
        tests_run++;
        if (resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mr_buffered: resp_valid=%b, required 1", resp_valid);
        end
`ifdef MULT_RR_STATS_EN
        tests_run++;
        if (done_count !== 16'(done_model)) begin
            tests_failed++;
            $display("FAIL done_count: value=%0d, required %0d", done_count, done_model);
        end
`endif
        base = resp_count;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mr_cleared: resp_valid=%b, required 0", resp_valid);
        end
`ifdef MULT_RR_STATS_EN
        tests_run++;
        if (done_count !== 16'd0 || stall_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_reset: done=%0d stall=%0d, required 0/0", done_count, stall_count);
        end
`endif
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            tests_run++;
            if (resp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mr_stale: cycle %0d resp_valid=%b id=%0d, required 0", k, resp_valid, resp_id);
            end
        end
        tests_run++;
        if (resp_count !== base) begin
            tests_failed++;
            $display("FAIL mr_count: responses=%0d, required %0d", resp_count, base);
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_corner();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one combinational 4x4 `array_multiplier` instance among NREQ requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Two-stage registered pipeline: operand stage, then result stage.
- Returns each product tagged with the ID of the requester that issued it; sits between client blocks and the multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_a  input  4*NREQ  packed multiplicands; requester i uses bits [4i+3:4i]
- req_b  input  4*NREQ  packed multipliers; same packing as req_a
- resp_valid  output  1  result valid
- resp_ready  input  1  downstream accepts result
- resp_id  output  ID_W  index of the requester whose product is presented
- resp_product  output  8  unsigned 8-bit product a*b

Behaviour:
- **Reset:** synchronous, active-high. When rst is sampled high:
  - s1_valid, s2_valid, resp_valid = 0.
  - resp_id = 0, resp_product = 0.
  - RR pointer = 0.
  - Operand registers = 0.
  - req_ready = 0 while rst is high.
- **Reset mid-operation:** in-flight operations are discarded; no response is emitted for them.
- **Handshakes:** transfer occurs when valid and ready are both high at a rising edge. A requester must hold req_valid, req_a and req_b stable until accepted.
- **Arbitration (combinational):**
  - Scan req_valid starting at index ptr, wrapping modulo NREQ; the first set bit is the winner.
  - req_ready[winner] = s1_adv; all other bits are 0.
  - No winner → req_ready = 0.
- **Pointer update:** on accept, ptr <= (winner+1) mod NREQ. Without an accept, ptr holds. Wrap from NREQ-1 goes to 0.
- **Pipeline advance:**
  - s2_adv = !s2_valid | resp_ready.
  - s1_adv = !s1_valid | s2_adv.
- **Stage 1:**
  - If s1_adv: s1_valid <= accept. On accept, also load s1_a, s1_b, s1_id from the winner.
  - If !s1_adv: stage 1 holds.
- **Multiplier:** the array_multiplier instance has inputs s1_a, s1_b and drives a combinational 8-bit product.
- **Stage 2:**
  - If s2_adv: s2_valid <= s1_valid. When s1_valid, also load resp_product <= product and resp_id <= s1_id.
  - If !s2_adv: outputs hold stable.
- **Outputs:** resp_valid = s2_valid.
- **Latency:** accept at edge T → resp_valid high after edge T+1, when there is no stall.
- **Throughput:** one operation per cycle with resp_ready held high.
- **Backpressure:** with resp_ready low, at most 2 operations are buffered. The third request sees req_ready=0.
- **Simultaneous events:** a response accept and a new request accept in the same cycle are both honoured, so the pipeline flows.
- **Ordering:** responses leave in acceptance order.
- **Arithmetic:** unsigned. Maximum value is 15*15 = 225 = 8'hE1; no overflow is possible.
- req_valid deasserted before accept is legal; no state change results.

Optional Feature:
- Macro: MULT_RR_STATS_EN.
- **When defined:**
  - Adds output port done_count (16 bits).
  - done_count increments on every resp_valid&resp_ready.
  - It wraps from 16'hFFFF to 0 and resets to 0.
  - Adds output port stall_count (16 bits). It increments each cycle that resp_valid & !resp_ready, saturates at 16'hFFFF, and resets to 0.
- **When undefined:** neither port nor counter exists; all other behaviour is identical.

Test Plan:
- **Reset/idle:** assert rst for 2 cycles with req_valid=4'b1111 → req_ready=0, resp_valid=0, resp_product=0. First accept after release goes to requester 0.
- **Single request:** requester 2 sends a=4'd13, b=4'd11 → req_ready[2] is high in the same cycle. Two cycles after accept, resp_valid=1, resp_id=2, resp_product=8'd143.
- **Round-robin fairness:** all four valid continuously with a=i+1, b=15 and resp_ready=1 → grant order 0,1,2,3,0,… Products 15,30,45,60 are returned in order, one per cycle.
- **Backpressure:** resp_ready=0 with requesters 0 and 1 valid → exactly 2 accepts, then req_ready=0. resp_valid/resp_id/resp_product stay stable. Raising resp_ready drains both in order with no loss or duplication.
- **Corner values:** 15*15 → 8'hE1; 0*9 → 0; 1*7 → 7. NREQ-1 is granted and the pointer wraps to 0 for the next grant.
- **Mid-operation reset:** with 2 operations buffered, assert rst for 1 cycle → resp_valid=0 the next cycle and no stale response ever appears. With MULT_RR_STATS_EN, done_count counts exactly the completed handshakes and returns to 0 on reset.
